// File: rtl/multdiv_unit.sv
// rtl/multdiv_unit.sv - multicycle signed multiply/divide unit, one bit per cycle
module multdiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             ctrl_MULT,
   input  logic             ctrl_DIV,
   input  logic             flush,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   output logic [WIDTH-1:0] data_result,
   output logic             data_exception,
   output logic             data_resultRDY,
   output logic             busy
);

   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               is_mul_q, is_mul_d;
   logic               neg_q, neg_d;
   logic               div_zero_q, div_zero_d;
   // Multiply: mcand = |A|, mplier = |B| (shifted right).
   // Divide:   mcand = |B| divisor, mplier = |A| dividend shifted left into quotient.
   logic [WIDTH-1:0]   mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   // Multiply: 2*WIDTH product accumulator. Divide: partial remainder in the low WIDTH+1 bits.
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               exc_q, exc_d;
   logic               rdy_q, rdy_d;

   logic [WIDTH-1:0]   abs_a, abs_b;
   logic [WIDTH-1:0]   mul_addend;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH:0]     div_trial;
   logic [WIDTH+1:0]   div_diff;
   logic [2*WIDTH-1:0] prod_s;
   logic [WIDTH-1:0]   quo_s;
   logic               prod_ovf;
   logic               div_ovf;

   // Datapath helpers, next-state and output logic
   always_comb begin
      abs_a      = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
      abs_b      = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
      mul_addend = mplier_q[0] ? mcand_q : {WIDTH{1'b0}};
      mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};
      div_trial  = {acc_q[WIDTH-1:0], mplier_q[WIDTH-1]};
      div_diff   = {1'b0, div_trial} - {2'b00, mcand_q};
      prod_s     = neg_q ? -acc_q : acc_q;
      quo_s      = neg_q ? -mplier_q : mplier_q;
      // Product overflows when the high half is not the sign extension of the low half
      prod_ovf   = prod_s[2*WIDTH-1:WIDTH-1] != {(WIDTH+1){prod_s[WIDTH-1]}};
      // A positive quotient of magnitude 2^(WIDTH-1) only arises from MIN_INT / -1
      div_ovf    = mplier_q[WIDTH-1] & ~neg_q;

      state_d    = state_q;
      cnt_d      = cnt_q;
      is_mul_d   = is_mul_q;
      neg_d      = neg_q;
      div_zero_d = div_zero_q;
      mcand_d    = mcand_q;
      mplier_d   = mplier_q;
      acc_d      = acc_q;
      result_d   = result_q;
      exc_d      = exc_q;
      rdy_d      = 1'b0;

      case (state_q)
         RUN: begin
            if (cnt_q == CNT_LAST) begin
               state_d = DONE;
               rdy_d   = 1'b1;
               if (is_mul_q) begin
                  result_d = prod_s[WIDTH-1:0];
                  exc_d    = prod_ovf;
               end else if (div_zero_q) begin
                  result_d = {WIDTH{1'b0}};
                  exc_d    = 1'b1;
               end else begin
                  result_d = quo_s;
                  exc_d    = div_ovf;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
               if (is_mul_q) begin
                  acc_d    = {mul_sum, acc_q[WIDTH-1:1]};
                  mplier_d = mplier_q >> 1;
               end else if (!div_diff[WIDTH+1]) begin
                  acc_d    = {{(WIDTH-1){1'b0}}, div_diff[WIDTH:0]};
                  mplier_d = {mplier_q[WIDTH-2:0], 1'b1};
               end else begin
                  acc_d    = {{(WIDTH-1){1'b0}}, div_trial};
                  mplier_d = {mplier_q[WIDTH-2:0], 1'b0};
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = state_q;
      endcase

      // Flush beats start; either one abandons whatever RUN was about to deliver
      if (flush) begin
         if (state_q != IDLE) begin
            state_d  = IDLE;
            rdy_d    = 1'b0;
            result_d = result_q;
            exc_d    = exc_q;
         end
      end else if (ctrl_MULT || ctrl_DIV) begin
         state_d    = RUN;
         cnt_d      = {CW{1'b0}};
         acc_d      = {(2*WIDTH){1'b0}};
         is_mul_d   = ctrl_MULT;
         neg_d      = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
         div_zero_d = ~ctrl_MULT & (data_operandB == {WIDTH{1'b0}});
         mcand_d    = ctrl_MULT ? abs_a : abs_b;
         mplier_d   = ctrl_MULT ? abs_b : abs_a;
         rdy_d      = 1'b0;
         result_d   = result_q;
         exc_d      = exc_q;
      end
   end

   // State and datapath registers
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         is_mul_q   <= 1'b0;
         neg_q      <= 1'b0;
         div_zero_q <= 1'b0;
         mcand_q    <= '0;
         mplier_q   <= '0;
         acc_q      <= '0;
         result_q   <= '0;
         exc_q      <= 1'b0;
         rdy_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         is_mul_q   <= is_mul_d;
         neg_q      <= neg_d;
         div_zero_q <= div_zero_d;
         mcand_q    <= mcand_d;
         mplier_q   <= mplier_d;
         acc_q      <= acc_d;
         result_q   <= result_d;
         exc_q      <= exc_d;
         rdy_q      <= rdy_d;
      end
   end

   assign data_result    = result_q;
   assign data_exception = exc_q;
   assign data_resultRDY = rdy_q;
   assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_multdiv_unit.sv
// tb/tb_multdiv_unit.sv - directed self-checking bench for multdiv_unit
module tb_multdiv_unit;

   logic        clock;
   logic        rst32, rst8;
   logic        m32, d32, fl32;
   logic [31:0] a32, b32;
   logic [31:0] res32;
   logic        exc32, rdy32, busy32;
   logic        m8, d8, fl8;
   logic [7:0]  a8, b8;
   logic [7:0]  res8;
   logic        exc8, rdy8, busy8;

   int checks;
   int failures;

   multdiv_unit #(.WIDTH(32)) dut32 (
      .clock(clock), .reset(rst32), .ctrl_MULT(m32), .ctrl_DIV(d32), .flush(fl32),
      .data_operandA(a32), .data_operandB(b32), .data_result(res32),
      .data_exception(exc32), .data_resultRDY(rdy32), .busy(busy32)
   );

   multdiv_unit #(.WIDTH(8)) dut8 (
      .clock(clock), .reset(rst8), .ctrl_MULT(m8), .ctrl_DIV(d8), .flush(fl8),
      .data_operandA(a8), .data_operandB(b8), .data_result(res8),
      .data_exception(exc8), .data_resultRDY(rdy8), .busy(busy8)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   // Start a 32-bit op, then watch 40 edges: first ready edge, captured outputs, pulse and busy counts
   task automatic op32(input bit mul, input logic [31:0] a, input logic [31:0] b,
                       output int lat, output logic [31:0] res, output logic exc,
                       output int pulses, output int bcyc);
      a32 = a; b32 = b;
      if (mul) m32 = 1'b1; else d32 = 1'b1;
      step();
      m32 = 1'b0; d32 = 1'b0;
      a32 = 32'hDEAD_BEEF; b32 = 32'h1234_5678;
      lat = -1; pulses = 0; res = '0; exc = 1'b0;
      bcyc = busy32 ? 1 : 0;
      for (int k = 1; k <= 40; k++) begin
         step();
         if (rdy32) begin
            pulses++;
            if (lat < 0) begin
               lat = k; res = res32; exc = exc32;
            end
         end
         if (busy32) bcyc++;
      end
   endtask

   task automatic test_reset();
      rst32 = 1'b0; rst8 = 1'b0;
      m32 = 0; d32 = 0; fl32 = 0; a32 = 0; b32 = 0;
      m8 = 0; d8 = 0; fl8 = 0; a8 = 0; b8 = 0;
      step(); step();
      checks++;
      if ({res32, exc32, rdy32, busy32} !== 35'd0) begin
         failures++;
         $display("FAIL reset32 got res=%h exc=%b rdy=%b busy=%b want all 0", res32, exc32, rdy32, busy32);
      end
      checks++;
      if ({res8, exc8, rdy8, busy8} !== 11'd0) begin
         failures++;
         $display("FAIL reset8 got res=%h exc=%b rdy=%b busy=%b want all 0", res8, exc8, rdy8, busy8);
      end
      rst32 = 1'b1; rst8 = 1'b1;
      step(); step();
      checks++;
      if (busy32 !== 1'b0 || rdy32 !== 1'b0) begin
         failures++;
         $display("FAIL idle_after_release got busy=%b rdy=%b want 0 0", busy32, rdy32);
      end
   endtask

   task automatic test_mult();
      int lat, pulses, bcyc;
      logic [31:0] res;
      logic exc;
      op32(1'b1, 32'd7, -32'sd6, lat, res, exc, pulses, bcyc);
      checks++;
      if (lat !== 33 || pulses !== 1) begin
         failures++;
         $display("FAIL mul_latency got lat=%0d pulses=%0d want 33 1", lat, pulses);
      end
      checks++;
      if (res !== 32'hFFFF_FFD6 || exc !== 1'b0) begin
         failures++;
         $display("FAIL mul_7x-6 got %h exc=%b want ffffffd6 0", res, exc);
      end
      checks++;
      if (bcyc !== 34) begin
         failures++;
         $display("FAIL mul_busy_cycles got %0d want 34", bcyc);
      end
      op32(1'b1, 32'h4000_0000, 32'd4, lat, res, exc, pulses, bcyc);
      checks++;
      if (res !== 32'h0 || exc !== 1'b1 || lat !== 33) begin
         failures++;
         $display("FAIL mul_ovf got %h exc=%b lat=%0d want 00000000 1 33", res, exc, lat);
      end
      op32(1'b1, 32'h8000_0000, 32'd1, lat, res, exc, pulses, bcyc);
      checks++;
      if (res !== 32'h8000_0000 || exc !== 1'b0) begin
         failures++;
         $display("FAIL mul_minint got %h exc=%b want 80000000 0", res, exc);
      end
   endtask

   task automatic test_div();
      int lat, pulses, bcyc;
      logic [31:0] res;
      logic exc;
      op32(1'b0, -32'sd43, 32'd5, lat, res, exc, pulses, bcyc);
      checks++;
      if (res !== 32'hFFFF_FFF8 || exc !== 1'b0 || lat !== 33) begin
         failures++;
         $display("FAIL div_-43/5 got %h exc=%b lat=%0d want fffffff8 0 33", res, exc, lat);
      end
      op32(1'b0, 32'd5, 32'd0, lat, res, exc, pulses, bcyc);
      checks++;
      if (res !== 32'h0 || exc !== 1'b1) begin
         failures++;
         $display("FAIL div_by_zero got %h exc=%b want 00000000 1", res, exc);
      end
      op32(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, lat, res, exc, pulses, bcyc);
      checks++;
      if (res !== 32'h8000_0000 || exc !== 1'b1) begin
         failures++;
         $display("FAIL div_minint/-1 got %h exc=%b want 80000000 1", res, exc);
      end
      op32(1'b0, 32'd100, 32'd7, lat, res, exc, pulses, bcyc);
      checks++;
      if (res !== 32'd14 || exc !== 1'b0) begin
         failures++;
         $display("FAIL div_100/7 got %h exc=%b want 0000000e 0", res, exc);
      end
   endtask

   task automatic test_restart();
      int pulses, at;
      logic [31:0] res;
      a32 = 32'd100; b32 = 32'd7; d32 = 1'b1;
      step();
      d32 = 1'b0;
      pulses = 0; at = -1; res = '0;
      for (int k = 1; k <= 9; k++) begin
         step();
         if (rdy32) pulses++;
      end
      a32 = 32'd3; b32 = 32'd3; m32 = 1'b1;
      step();
      m32 = 1'b0;
      if (rdy32) pulses++;
      for (int k = 11; k <= 50; k++) begin
         step();
         if (rdy32) begin
            pulses++;
            if (at < 0) begin
               at = k; res = res32;
            end
         end
      end
      checks++;
      if (pulses !== 1 || at !== 43) begin
         failures++;
         $display("FAIL restart_pulse got pulses=%0d at=%0d want 1 43", pulses, at);
      end
      checks++;
      if (res !== 32'd9) begin
         failures++;
         $display("FAIL restart_result got %h want 00000009", res);
      end
   endtask

   task automatic test_flush();
      int pulses;
      a32 = 32'd5; b32 = 32'd5; m32 = 1'b1;
      step();
      m32 = 1'b0;
      for (int k = 1; k <= 4; k++) step();
      fl32 = 1'b1;
      step();
      fl32 = 1'b0;
      checks++;
      if (busy32 !== 1'b0) begin
         failures++;
         $display("FAIL flush_busy got %b want 0", busy32);
      end
      pulses = 0;
      for (int k = 0; k < 40; k++) begin
         step();
         if (rdy32) pulses++;
      end
      checks++;
      if (pulses !== 0 || res32 !== 32'd9) begin
         failures++;
         $display("FAIL flush_hold got pulses=%0d res=%h want 0 00000009", pulses, res32);
      end
      a32 = 32'd50; b32 = 32'd5; fl32 = 1'b1; d32 = 1'b1;
      step();
      fl32 = 1'b0; d32 = 1'b0;
      checks++;
      if (busy32 !== 1'b0) begin
         failures++;
         $display("FAIL flush_start_same_cycle got busy=%b want 0", busy32);
      end
      pulses = 0;
      for (int k = 0; k < 40; k++) begin
         step();
         if (rdy32) pulses++;
      end
      checks++;
      if (pulses !== 0) begin
         failures++;
         $display("FAIL flush_start_no_pulse got %0d want 0", pulses);
      end
   endtask

   task automatic test_back_to_back();
      int seen, lat;
      logic [31:0] res;
      a32 = 32'd2; b32 = 32'd3; m32 = 1'b1;
      step();
      m32 = 1'b0;
      seen = 0;
      for (int k = 1; k <= 40 && seen == 0; k++) begin
         step();
         if (rdy32) seen = k;
      end
      checks++;
      if (seen !== 33 || res32 !== 32'd6) begin
         failures++;
         $display("FAIL b2b_first got at=%0d res=%h want 33 00000006", seen, res32);
      end
      a32 = 32'd100; b32 = -32'sd7; d32 = 1'b1;
      step();
      d32 = 1'b0;
      lat = -1; res = '0;
      for (int k = 1; k <= 40; k++) begin
         step();
         if (rdy32 && lat < 0) begin
            lat = k; res = res32;
         end
      end
      checks++;
      if (lat !== 33 || res !== 32'hFFFF_FFF2) begin
         failures++;
         $display("FAIL b2b_second got lat=%0d res=%h want 33 fffffff2", lat, res);
      end
   endtask

   task automatic test_width8();
      int lat, pulses;
      logic [7:0] res;
      logic exc;
      a8 = 8'h80; b8 = 8'hFF; m8 = 1'b1;
      step();
      m8 = 1'b0;
      lat = -1; res = '0; exc = 1'b0;
      for (int k = 1; k <= 20; k++) begin
         step();
         if (rdy8 && lat < 0) begin
            lat = k; res = res8; exc = exc8;
         end
      end
      checks++;
      if (lat !== 9 || res !== 8'h80 || exc !== 1'b1) begin
         failures++;
         $display("FAIL w8_mul got lat=%0d res=%h exc=%b want 9 80 1", lat, res, exc);
      end
      a8 = 8'd5; b8 = 8'd5; m8 = 1'b1;
      step();
      m8 = 1'b0;
      for (int k = 1; k <= 3; k++) step();
      #2 rst8 = 1'b0;
      #1;
      checks++;
      if ({res8, exc8, rdy8, busy8} !== 11'd0) begin
         failures++;
         $display("FAIL w8_async_reset got res=%h exc=%b rdy=%b busy=%b want all 0", res8, exc8, rdy8, busy8);
      end
      step();
      rst8 = 1'b1;
      pulses = 0;
      for (int k = 0; k < 20; k++) begin
         step();
         if (rdy8 || busy8) pulses++;
      end
      checks++;
      if (pulses !== 0) begin
         failures++;
         $display("FAIL w8_no_pulse_after_reset got %0d active cycles want 0", pulses);
      end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      test_reset();
      test_mult();
      test_div();
      test_restart();
      test_flush();
      test_back_to_back();
      test_width8();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
